// File: rtl/matrix_arb_pkg.sv
// Shared types and widths for the storage write-port arbiter.
package matrix_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_OFFER   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

  localparam int MAX_REQ    = 8;
  localparam int NAME_BYTES = 8;
  localparam int ID_W       = 3;
  localparam int DATA_W     = 32;

endpackage

// File: rtl/matrix_write_arbiter_rr_picker.sv
// Combinational round-robin search: first claiming index strictly after last_grant, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int LG_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] claim,
  input  logic [LG_W-1:0]    last_grant,
  output logic               pick_valid,
  output logic [LG_W-1:0]    pick_idx
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_claim;
  logic [NUM_REQ-1:0] sel_vec;
  logic [NUM_REQ-1:0] first_hot;
  logic               seen [0:NUM_REQ];
  logic [LG_W-1:0]    acc  [0:NUM_REQ];

  // Prefer claims above last_grant; if none, wrap to the lowest claim overall.
  assign hi_claim = claim & hi_mask;
  assign sel_vec  = (|hi_claim) ? hi_claim : claim;
  assign seen[0]  = 1'b0;
  assign acc[0]   = '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      assign hi_mask[gi]   = LG_W'(gi) > last_grant;
      assign first_hot[gi] = sel_vec[gi] & ~seen[gi];
      assign seen[gi+1]    = seen[gi] | sel_vec[gi];
      assign acc[gi+1]     = acc[gi] | (first_hot[gi] ? LG_W'(gi) : '0);
    end
  endgenerate

  assign pick_valid = |claim;
  assign pick_idx   = acc[NUM_REQ];

endmodule

// File: rtl/matrix_write_arbiter.sv
// Round-robin owner of the storage manager's single write port; grant held until write_done.
module matrix_write_arbiter
  import matrix_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_claim,
  input  logic [NUM_REQ-1:0]                   req_write_request,
  output logic [NUM_REQ-1:0]                   req_write_ready,
  input  logic [NUM_REQ-1:0][ID_W-1:0]         req_matrix_id,
  input  logic [NUM_REQ-1:0][7:0]              req_rows,
  input  logic [NUM_REQ-1:0][7:0]              req_cols,
  input  logic [NUM_REQ-1:0][8*NAME_BYTES-1:0] req_name,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data_in,
  input  logic [NUM_REQ-1:0]                   req_data_valid,
  output logic [NUM_REQ-1:0]                   req_writer_ready,
  output logic [NUM_REQ-1:0]                   req_write_done,
  output logic                                 write_request,
  input  logic                                 write_ready,
  output logic [ID_W-1:0]                      matrix_id,
  output logic [7:0]                           actual_rows,
  output logic [7:0]                           actual_cols,
  output logic [7:0]                           matrix_name [0:NAME_BYTES-1],
  output logic [DATA_W-1:0]                    data_in,
  output logic                                 data_valid,
  input  logic                                 write_done,
  input  logic                                 writer_ready,
  output logic                                 grant_valid,
  output logic [ID_W-1:0]                      grant_id,
  output logic                                 abort
);

  localparam int LG_W = $clog2(NUM_REQ);

  arb_state_t      state_reg, state_next;
  logic [LG_W-1:0] grant_reg;
  logic [LG_W-1:0] last_grant_reg;
  logic            pick_valid;
  logic [LG_W-1:0] pick_idx;
  logic            in_offer, in_stream, hdr_on, handshake;

  rr_picker #(.NUM_REQ(NUM_REQ), .LG_W(LG_W)) u_picker (
    .claim      (req_claim),
    .last_grant (last_grant_reg),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  assign in_offer  = (state_reg == ST_OFFER);
  assign in_stream = (state_reg == ST_STREAM);
  assign hdr_on    = in_offer | in_stream;
  assign handshake = in_offer & req_write_request[grant_reg] & write_ready;
  // A request that completes the handshake wins over a simultaneous claim drop.
  assign abort     = in_offer & ~req_claim[grant_reg] & ~handshake;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (|req_claim) state_next = ST_SELECT;
      ST_SELECT:  state_next = pick_valid ? ST_OFFER : ST_IDLE;
      ST_OFFER: begin
        if (handshake)  state_next = ST_STREAM;
        else if (abort) state_next = ST_IDLE;
      end
      ST_STREAM:  if (write_done) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LG_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_SELECT && pick_valid) grant_reg <= pick_idx;
      if (state_reg == ST_RELEASE) last_grant_reg <= grant_reg;
    end
  end

  assign write_request = handshake;
  assign data_valid    = in_stream & req_data_valid[grant_reg];
  assign data_in       = in_stream ? req_data_in[grant_reg] : '0;
  assign matrix_id     = hdr_on ? req_matrix_id[grant_reg] : '0;
  assign actual_rows   = hdr_on ? req_rows[grant_reg] : '0;
  assign actual_cols   = hdr_on ? req_cols[grant_reg] : '0;
  assign grant_valid   = hdr_on;
  assign grant_id      = ID_W'(grant_reg);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      logic is_win;
      assign is_win               = (grant_reg == LG_W'(gi));
      assign req_write_ready[gi]  = in_offer & is_win & write_ready;
      assign req_writer_ready[gi] = in_stream & is_win & writer_ready;
      assign req_write_done[gi]   = in_stream & is_win & write_done;
    end
    for (genvar gi = 0; gi < NAME_BYTES; gi++) begin : g_name
      assign matrix_name[gi] = hdr_on ? req_name[grant_reg][8*gi +: 8] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Directed bench: per-cycle vector table for one producer, then hand sequences for arbitration corners.
module tb_matrix_write_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_claim, req_write_request, req_write_ready;
  logic [2:0][2:0]  req_matrix_id;
  logic [2:0][7:0]  req_rows, req_cols;
  logic [2:0][63:0] req_name;
  logic [2:0][31:0] req_data_in;
  logic [2:0]       req_data_valid, req_writer_ready, req_write_done;
  logic             write_request, write_ready;
  logic [2:0]       matrix_id;
  logic [7:0]       actual_rows, actual_cols;
  logic [7:0]       matrix_name [0:7];
  logic [31:0]      data_in;
  logic             data_valid, write_done, writer_ready;
  logic             grant_valid, abort;
  logic [2:0]       grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_write_arbiter #(.NUM_REQ(3)) dut (
    .clk(clk), .rst(rst),
    .req_claim(req_claim), .req_write_request(req_write_request),
    .req_write_ready(req_write_ready), .req_matrix_id(req_matrix_id),
    .req_rows(req_rows), .req_cols(req_cols), .req_name(req_name),
    .req_data_in(req_data_in), .req_data_valid(req_data_valid),
    .req_writer_ready(req_writer_ready), .req_write_done(req_write_done),
    .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
    .write_done(write_done), .writer_ready(writer_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .abort(abort)
  );

  typedef struct {
    logic [2:0]  claim, wreq, dv;
    logic        wd;
    logic [31:0] d;
    logic        gv;
    logic [2:0]  gid;
    logic        wrq, odv;
    logic [31:0] data;
    logic [2:0]  rwr, rwrr, rwd;
    logic        ab;
    logic [2:0]  mid;
  } vec_t;

  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [7:0] nm_or;
    nm_or = '0;
    for (int k = 0; k < 8; k++) nm_or |= matrix_name[k];
    chk({tag, "_ctl"}, 64'({grant_valid, abort, write_request, data_valid}), 64'd0);
    chk({tag, "_data"}, 64'(data_in), 64'd0);
    chk({tag, "_gid"}, 64'(grant_id), 64'd0);
    chk({tag, "_hdr"}, 64'({matrix_id, actual_rows, actual_cols, nm_or}), 64'd0);
    chk({tag, "_req"}, 64'({req_write_ready, req_writer_ready, req_write_done}), 64'd0);
  endtask

  task automatic set_data(input int b);
    for (int p = 0; p < 3; p++) req_data_in[p] = 32'(b) + 32'(p) * 32'h1000;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grant(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (grant_valid) found = 1'b1;
    end
  endtask

  // One full write by producer g; non-winners toggle their strobes as noise while it streams.
  task automatic serve(input int g, input int beats, input bit drop, input logic [2:0] extra);
    bit         found;
    logic [2:0] oh, noise;
    oh = 3'b001 << g;
    wait_grant(found);
    chk($sformatf("g%0d_grant_seen", g), 64'(found), 64'd1);
    if (!found) return;
    chk($sformatf("g%0d_grant_id", g), 64'(grant_id), 64'(g));
    chk($sformatf("g%0d_hdr", g), 64'({matrix_id, actual_rows, actual_cols}),
        64'({3'(g + 3), 8'(g + 1), 8'(g + 1)}));
    chk($sformatf("g%0d_name7", g), 64'(matrix_name[7]), 64'(8'(16 * g + 7)));
    chk($sformatf("g%0d_offer_wready", g), 64'(req_write_ready), 64'(oh));
    req_claim = req_claim | extra;
    req_write_request = oh;
    #1 chk($sformatf("g%0d_write_request", g), 64'(write_request), 64'd1);
    @(posedge clk);
    #1 req_write_request = '0;
    for (int b = 1; b <= beats; b++) begin
      noise = (b % 2 == 1) ? ~oh : 3'b000;
      req_data_valid = oh | noise;
      req_write_request = noise;
      set_data(b);
      @(negedge clk);
      chk($sformatf("g%0d_b%0d_dv", g, b), 64'(data_valid), 64'd1);
      chk($sformatf("g%0d_b%0d_data", g, b), 64'(data_in), 64'(32'(b) + 32'(g) * 32'h1000));
      chk($sformatf("g%0d_b%0d_wreq_iso", g, b), 64'(write_request), 64'd0);
      chk($sformatf("g%0d_b%0d_req_out", g, b),
          64'({req_writer_ready, req_write_ready}), 64'({oh, 3'b000}));
      @(posedge clk);
      #1;
    end
    req_data_valid = ~oh;
    req_write_request = ~oh;
    write_done = 1'b1;
    @(negedge clk);
    chk($sformatf("g%0d_done_dv_iso", g), 64'({data_valid, write_request}), 64'd0);
    chk($sformatf("g%0d_write_done", g), 64'(req_write_done), 64'(oh));
    if (drop) req_claim = req_claim & ~oh;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    req_data_valid = '0;
    req_write_request = '0;
    @(negedge clk);
    chk($sformatf("g%0d_release_gv", g), 64'(grant_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors %0d", errors);
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1;
    req_claim = '0; req_write_request = '0; req_data_valid = '0;
    write_ready = 1'b1; writer_ready = 1'b1; write_done = 1'b0;
    set_data(0);
    for (int p = 0; p < 3; p++) begin
      req_matrix_id[p] = 3'(p + 3);
      req_rows[p] = 8'(p + 1);
      req_cols[p] = 8'(p + 1);
      for (int k = 0; k < 8; k++) req_name[p][8*k +: 8] = 8'(16 * p + k);
    end

    //        claim   wreq    dv      wd    d       gv    gid   wrq   odv   data        rwr     rwrr    rwd     ab    mid
    tbl[0]  = '{3'b010, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[1]  = '{3'b010, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[2]  = '{3'b010, 3'b010, 3'b000, 1'b0, 32'd0, 1'b1, 3'd1, 1'b1, 1'b0, 32'h0,      3'b010, 3'b000, 3'b000, 1'b0, 3'd4};
    tbl[3]  = '{3'b010, 3'b000, 3'b010, 1'b0, 32'd1, 1'b1, 3'd1, 1'b0, 1'b1, 32'h1001,   3'b000, 3'b010, 3'b000, 1'b0, 3'd4};
    tbl[4]  = '{3'b010, 3'b000, 3'b010, 1'b0, 32'd2, 1'b1, 3'd1, 1'b0, 1'b1, 32'h1002,   3'b000, 3'b010, 3'b000, 1'b0, 3'd4};
    tbl[5]  = '{3'b010, 3'b000, 3'b010, 1'b0, 32'd3, 1'b1, 3'd1, 1'b0, 1'b1, 32'h1003,   3'b000, 3'b010, 3'b000, 1'b0, 3'd4};
    tbl[6]  = '{3'b010, 3'b000, 3'b010, 1'b0, 32'd4, 1'b1, 3'd1, 1'b0, 1'b1, 32'h1004,   3'b000, 3'b010, 3'b000, 1'b0, 3'd4};
    tbl[7]  = '{3'b010, 3'b000, 3'b000, 1'b1, 32'd0, 1'b1, 3'd1, 1'b0, 1'b0, 32'h1000,   3'b000, 3'b010, 3'b010, 1'b0, 3'd4};
    tbl[8]  = '{3'b000, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[9]  = '{3'b010, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[10] = '{3'b010, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[11] = '{3'b000, 3'b000, 3'b000, 1'b0, 32'd0, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0,      3'b010, 3'b000, 3'b000, 1'b1, 3'd4};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,      3'b000, 3'b000, 3'b000, 1'b0, 3'd0};

    apply_reset();

    // Single producer on index 1, then re-claim after release and withdraw in OFFER.
    for (int i = 0; i <= 12; i++) begin
      req_claim = tbl[i].claim;
      req_write_request = tbl[i].wreq;
      req_data_valid = tbl[i].dv;
      write_done = tbl[i].wd;
      set_data(int'(tbl[i].d));
      @(negedge clk);
      chk($sformatf("row%0d_gv", i), 64'(grant_valid), 64'(tbl[i].gv));
      chk($sformatf("row%0d_gid", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("row%0d_wreq_dv", i), 64'({write_request, data_valid}), 64'({tbl[i].wrq, tbl[i].odv}));
      chk($sformatf("row%0d_data", i), 64'(data_in), 64'(tbl[i].data));
      chk($sformatf("row%0d_req_out", i), 64'({req_write_ready, req_writer_ready, req_write_done}),
          64'({tbl[i].rwr, tbl[i].rwrr, tbl[i].rwd}));
      chk($sformatf("row%0d_abort", i), 64'(abort), 64'(tbl[i].ab));
      chk($sformatf("row%0d_mid", i), 64'(matrix_id), 64'(tbl[i].mid));
      @(posedge clk);
      #1;
    end
    req_claim = '0; write_done = 1'b0; req_data_valid = '0; req_write_request = '0;

    // Contention from reset: 0,2,0,2; index 1 joins during the fourth grant.
    req_claim = 3'b101;
    apply_reset();
    serve(0, 2, 1'b0, 3'b000);
    serve(2, 2, 1'b0, 3'b000);
    serve(0, 2, 1'b0, 3'b000);
    serve(2, 3, 1'b0, 3'b010);
    serve(0, 2, 1'b1, 3'b000);
    serve(1, 2, 1'b1, 3'b000);
    serve(2, 2, 1'b1, 3'b000);

    // Withdrawal: last_grant = 0, index 1 wins and drops its claim in OFFER.
    req_claim = 3'b001;
    serve(0, 1, 1'b1, 3'b000);
    req_claim = 3'b010;
    wait_grant(found);
    chk("wd_grant_seen", 64'(found), 64'd1);
    chk("wd_grant_id", 64'(grant_id), 64'd1);
    req_claim = 3'b000;
    #1 chk("wd_abort_pulse", 64'(abort), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wd_after_abort", 64'({abort, grant_valid}), 64'd0);
    req_claim = 3'b110;
    serve(1, 2, 1'b1, 3'b000);
    serve(2, 2, 1'b1, 3'b000);
    req_claim = 3'b010;
    serve(1, 1, 1'b1, 3'b000);

    // Reset mid-stream: index 2 streams (last_grant = 1), index 1 claims, rst after 3 beats.
    req_claim = 3'b100;
    wait_grant(found);
    chk("mr_grant_seen", 64'(found), 64'd1);
    chk("mr_grant_id", 64'(grant_id), 64'd2);
    req_write_request = 3'b100;
    @(posedge clk);
    #1 req_write_request = '0;
    for (int b = 1; b <= 3; b++) begin
      req_data_valid = 3'b100;
      set_data(b);
      @(negedge clk);
      chk($sformatf("mr_b%0d_data", b), 64'({data_valid, data_in}), 64'({1'b1, 32'(b) + 32'h2000}));
      @(posedge clk);
      #1;
    end
    set_data(4);
    req_claim = 3'b110;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    req_data_valid = '0;
    serve(1, 2, 1'b1, 3'b000);
    serve(2, 2, 1'b1, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_write_arbiter.md
# matrix_write_arbiter

Shares the single write port of the matrix storage manager among `NUM_REQ` producers: the input handler, the random-generation handler and the calculation-result writer. Each producer keeps its existing write handshake (`write_ready`/`write_request`, `writer_ready`/`data_valid`, `write_done`). The arbiter grants one producer at a time in round-robin order and holds that grant until the storage manager reports `write_done`. Non-granted producers see an idle port.

## Interface
Parameters:
- `NUM_REQ`, 3: number of producers (2..8); index 0 = input handler, 1 = random gen, 2 = calc result.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_claim`  in  NUM_REQ  level per producer; high while that producer wants the port.
- `req_write_request`  in  NUM_REQ  per-producer write request.
- `req_write_ready`  out  NUM_REQ  per-producer gated `write_ready`.
- `req_matrix_id`  in  NUM_REQ×3  per-producer target slot.
- `req_rows`, `req_cols`  in  NUM_REQ×8 each  per-producer dimensions.
- `req_name`  in  NUM_REQ×64  per-producer name; byte k at bits [8k+7:8k].
- `req_data_in`  in  NUM_REQ×32  per-producer element data.
- `req_data_valid`  in  NUM_REQ  per-producer element strobe.
- `req_writer_ready`  out  NUM_REQ  per-producer gated `writer_ready`.
- `req_write_done`  out  NUM_REQ  per-producer gated `write_done`.
- `write_request`  out  1  to storage manager.
- `write_ready`  in  1  from storage manager.
- `matrix_id`  out  3  to storage manager.
- `actual_rows`, `actual_cols`  out  8 each  to storage manager.
- `matrix_name`  out  8×[0:7]  to storage manager.
- `data_in`  out  32  to storage manager.
- `data_valid`  out  1  to storage manager.
- `write_done`  in  1  from storage manager.
- `writer_ready`  in  1  from storage manager.
- `grant_valid`  out  1  high in OFFER and STREAM.
- `grant_id`  out  3  registered winner index.
- `abort`  out  1  one-cycle pulse when a winner withdraws before requesting.

## Operation
- States: IDLE, SELECT, OFFER, STREAM, RELEASE.
- IDLE:
  - If any `req_claim` is high, go to SELECT.
- SELECT:
  - Winner is the first claiming index strictly after `last_grant`, searching cyclically.
  - Latch it into `grant_id`; go to OFFER.
  - If the claim vanished in the meantime, return to IDLE.
- OFFER:
  - `req_write_ready[grant_id] = write_ready`; all other `req_write_ready` are 0.
  - `write_request = req_write_request[grant_id] & write_ready`.
  - On that handshake, go to STREAM.
  - If `req_claim[grant_id]` drops without a handshake: pulse `abort`, go to IDLE, leave `last_grant` unchanged.
- STREAM:
  - `data_in` and `data_valid` are muxed from the winner.
  - `req_writer_ready[grant_id] = writer_ready`; `req_write_done[grant_id] = write_done`.
  - On `write_done`, go to RELEASE.
- RELEASE:
  - `last_grant <= grant_id`; go to IDLE.
  - Gives one idle cycle so the storage manager returns to ready.
- Header outputs (`matrix_id`, `actual_rows`, `actual_cols`, `matrix_name`) mux from `grant_id` in OFFER and STREAM, and are 0 otherwise.
- Non-winners always see 0 on every `req_*` output.
- `req_data_valid` from a non-winner is ignored.
- Claims arriving during OFFER, STREAM or RELEASE wait; no preemption.

## Timing
- Reset:
  - state = IDLE, `last_grant = NUM_REQ-1` (so index 0 wins first), `grant_id = 0`.
  - Every output is 0.
  - A reset mid-STREAM drops the grant immediately; the storage manager is reset by the same `rst`.
- Latency:
  - Claim sampled at edge N → SELECT at N+1 → OFFER at N+2.
  - The winner sees `req_write_ready` combinationally in the OFFER cycle.
- Pass-through paths in OFFER and STREAM are combinational, with zero added latency on `write_request`, `data_valid`, `writer_ready` and `write_done`.
- Minimum gap between two grants: the RELEASE cycle plus IDLE and SELECT, i.e. 3 cycles.
- `write_done` together with a new claim in the same cycle: RELEASE completes first, then the new arbitration uses the updated `last_grant`.
- No counters wider than `$clog2(NUM_REQ)`; `grant_id` is zero-extended to 3 bits.

## Structure
- Package `matrix_arb_pkg`: state enum `arb_state_t`, `MAX_REQ = 8`, `NAME_BYTES = 8`, `ID_W = 3`, `DATA_W = 32`.
- Sub-module `rr_picker`: combinational round-robin search.
  - Inputs: `claim` vector and `last_grant`.
  - Outputs: `pick_valid`, `pick_idx`.
- The arbiter holds the FSM, the `last_grant`/`grant_id` registers and the port muxes.

## Test plan
- Single producer: claim on index 1, `write_ready = 1`, 2×2 matrix, 4 `data_valid` beats, then `write_done`.
  - Storage side receives id, rows, cols and data 1..4 unchanged; `grant_id = 1`; back to IDLE 2 cycles after `write_done`.
- Contention: claims 0 and 2 both high from reset, each completing one write.
  - Grant order is 0, 2, 0, 2.
  - Index 1 added later is served after the next grant holder in cyclic order.
- Isolation: during STREAM for index 0, index 2 toggles `req_data_valid` and `req_write_request`.
  - Storage side never sees them.
  - `req_writer_ready[2]`, `req_write_ready[2]` and `req_write_done[2]` stay 0.
- Withdrawal: index 1 wins, then drops `req_claim` in OFFER without requesting.
  - `abort` pulses once; FSM returns to IDLE; `last_grant` unchanged, so index 1 can win again.
- Reset mid-stream: assert `rst` for 1 cycle after 3 of 6 beats.
  - All outputs 0 the next cycle; the first grant afterwards goes to the lowest claiming index.
- `write_done` while index 0 still claims: `last_grant = 0`, so a pending claim on index 2 wins next.
